// File: rtl/decoder_pkg.sv
// Shared decoder definitions: FSM state encoding and the one-hot helper
// used by this decoder and by later decoder/mux blocks.
package decoder_pkg;

    // Widest index any client decoder may use; onehot() works at this width
    // and callers size-cast the result down to their own N.
    localparam int MAX_SEL_W = 8;
    localparam int MAX_N     = 1 << MAX_SEL_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

    // Returns 1 << idx as a MAX_N-bit vector.
    function automatic logic [MAX_N-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
        logic [MAX_N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/onehot_scan_decoder_if.sv
// Index handshake and select outputs of the one-hot scan decoder.
interface onehot_scan_decoder_if #(
    parameter int SEL_W = 3
);
    localparam int N = 1 << SEL_W;

    logic             en;
    logic             mode;
    logic             sel_valid;
    logic [SEL_W-1:0] sel;
    logic             sel_ready;
    logic [N-1:0]     y;
    logic [SEL_W-1:0] active_idx;
    logic             wrap;

    modport master (
        output en, mode, sel_valid, sel,
        input  sel_ready, y, active_idx, wrap
    );

    modport slave (
        input  en, mode, sel_valid, sel,
        output sel_ready, y, active_idx, wrap
    );

endinterface

// File: rtl/onehot_scan_decoder_tick.sv
// Dwell counter for scan mode: counts 0..DWELL-1 while running and flags
// the last count so the decoder can step to the next index.
module scan_tick_gen #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_r;

    assign tick = run & (cnt_r == LAST);

    // Dwell count: clear has priority, wraps to zero after the last count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (run) begin
            if (cnt_r == LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered binary-to-one-hot decoder with direct (handshaked index) and
// auto-scan modes. y, active_idx and wrap are registered; sel_ready is a
// decode of the current state.
module onehot_scan_decoder
    import decoder_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int DWELL = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    onehot_scan_decoder_if.slave  bus
);

    localparam int N = 1 << SEL_W;

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_DIRECT = DIRECT;
    localparam logic [1:0] S_SCAN   = SCAN;

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [SEL_W-1:0] idx_r;
    logic [SEL_W-1:0] idx_nxt_s;
    logic [N-1:0]     y_r;
    logic [N-1:0]     y_nxt_s;
    logic             wrap_r;
    logic             wrap_nxt_s;
    logic             accept_s;
    logic             tick_s;
    logic             tick_clear_s;
    logic             tick_run_s;

    assign bus.sel_ready  = (state_r == S_DIRECT);
    assign bus.y          = y_r;
    assign bus.active_idx = idx_r;
    assign bus.wrap       = wrap_r;

    assign accept_s = bus.sel_valid & bus.sel_ready;

    // The counter only runs while staying in SCAN, so every entry into SCAN
    // starts the dwell from zero.
    assign tick_run_s   = (state_r == S_SCAN);
    assign tick_clear_s = (state_r != S_SCAN) | (state_nxt_s != S_SCAN);

    scan_tick_gen #(
        .DWELL (DWELL)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tick_clear_s),
        .run   (tick_run_s),
        .tick  (tick_s)
    );

    // Next state: enable dominates, then mode picks DIRECT or SCAN.
    always_comb begin
        state_nxt_s = S_IDLE;
        if (!bus.en) begin
            state_nxt_s = S_IDLE;
        end else if (!bus.mode) begin
            state_nxt_s = S_DIRECT;
        end else begin
            state_nxt_s = S_SCAN;
        end
    end

    // Next index, select and wrap pulse for the state being entered.
    always_comb begin
        idx_nxt_s  = idx_r;
        wrap_nxt_s = 1'b0;
        case (state_nxt_s)
            S_SCAN: begin
                if (state_r != S_SCAN) begin
                    idx_nxt_s = '0;
                end else if (tick_s) begin
                    idx_nxt_s  = idx_r + SEL_W'(1);
                    wrap_nxt_s = (idx_r == SEL_W'(N - 1));
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            default: begin
                // DIRECT and IDLE: an accepted index always lands in active_idx.
                if (accept_s) begin
                    idx_nxt_s = bus.sel;
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
        endcase
        if (state_nxt_s == S_IDLE) begin
            y_nxt_s = '0;
        end else begin
            y_nxt_s = N'(onehot(MAX_SEL_W'(idx_nxt_s)));
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            idx_r   <= '0;
            y_r     <= '0;
            wrap_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            y_r     <= y_nxt_s;
            wrap_r  <= wrap_nxt_s;
        end
    end

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Scoreboard bench for onehot_scan_decoder: directed stimulus pushes the
// expected outputs for the next edge; a monitor pops and compares them.
module tb_onehot_scan_decoder;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    // Cycle index used to tag when each expectation is due.
    always @(posedge clk) cyc <= cyc + 1;

    onehot_scan_decoder_if #(.SEL_W(3)) bus ();
    onehot_scan_decoder_if #(.SEL_W(2)) b2 ();
    onehot_scan_decoder_if #(.SEL_W(4)) b4 ();

    onehot_scan_decoder #(.SEL_W(3), .DWELL(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    onehot_scan_decoder #(.SEL_W(2), .DWELL(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    onehot_scan_decoder #(.SEL_W(4), .DWELL(3)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    typedef struct {
        int         due;
        logic [7:0] y;
        logic [2:0] idx;
        logic       wrap;
        logic       rdy;
        string      tag;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Drive inputs on the falling edge and queue the outputs expected after
    // the next rising edge.
    task automatic step(input logic e, input logic m, input logic v, input logic [2:0] s,
                        input logic [7:0] ey, input logic [2:0] ei, input logic ew,
                        input logic er, input string tag);
        exp_t x;
        @(negedge clk);
        bus.en = e; bus.mode = m; bus.sel_valid = v; bus.sel = s;
        x.due = cyc + 1; x.y = ey; x.idx = ei; x.wrap = ew; x.rdy = er; x.tag = tag;
        q.push_back(x);
    endtask

    // Monitor: compare every expectation due at this edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                tests++;
                if (e.due != cyc || bus.y !== e.y || bus.active_idx !== e.idx ||
                    bus.wrap !== e.wrap || bus.sel_ready !== e.rdy) begin
                    fails++;
                    $display("FAIL %s cyc=%0d: got y=%h idx=%0d wrap=%b rdy=%b want y=%h idx=%0d wrap=%b rdy=%b (due %0d)",
                             e.tag, cyc, bus.y, bus.active_idx, bus.wrap, bus.sel_ready,
                             e.y, e.idx, e.wrap, e.rdy, e.due);
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d tests run", tests);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  e2y;
        logic [15:0] e4y;
        int          wraps2;
        int          wraps4;
        int          first2;
        int          first4;

        rst_n = 1'b0;
        bus.en = 1'b0; bus.mode = 1'b0; bus.sel_valid = 1'b0; bus.sel = 3'd0;
        b2.en = 1'b0; b2.mode = 1'b0; b2.sel_valid = 1'b0; b2.sel = 2'd0;
        b4.en = 1'b0; b4.mode = 1'b0; b4.sel_valid = 1'b0; b4.sel = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {bus.y, 5'd0, bus.active_idx, 3'd0, bus.wrap, 3'd0, bus.sel_ready}, 32'h0);

        step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0, "idle_after_reset");
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b1, 3'd5, 8'h00, 3'd0, 1'b0, 1'b0, "idle_ignores_sel");

        // Direct decode, back-to-back accepts.
        step(1'b1, 1'b0, 1'b0, 3'd0, 8'h01, 3'd0, 1'b0, 1'b1, "direct_entry");
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b1, 3'(i), 8'h01 << i, 3'(i), 1'b0, 1'b1, "direct_decode");
        end
        step(1'b1, 1'b0, 1'b0, 3'd2, 8'h80, 3'd7, 1'b0, 1'b1, "direct_hold");

        // Scan sweep with sel_valid held high; runs on to index 5.
        for (int c = 0; c < 54; c++) begin
            step(1'b1, 1'b1, 1'b1, 3'd3, 8'h01 << ((c / 4) % 8), 3'((c / 4) % 8),
                 (c == 32), 1'b0, "scan_sweep");
        end

        // Mode switch mid-scan keeps the index; switching back restarts.
        step(1'b1, 1'b0, 1'b0, 3'd0, 8'h20, 3'd5, 1'b0, 1'b1, "scan_to_direct");
        step(1'b1, 1'b0, 1'b0, 3'd0, 8'h20, 3'd5, 1'b0, 1'b1, "direct_retained");
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 1'b1, 1'b0, 3'd0, 8'h01 << (c / 4), 3'(c / 4), 1'b0, 1'b0, "scan_restart");
        end

        // Disable during DIRECT at index 6, then re-enable.
        step(1'b1, 1'b0, 1'b0, 3'd0, 8'h02, 3'd1, 1'b0, 1'b1, "direct_from_scan");
        step(1'b1, 1'b0, 1'b1, 3'd6, 8'h40, 3'd6, 1'b0, 1'b1, "direct_idx6");
        step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd6, 1'b0, 1'b0, "disable");
        step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd6, 1'b0, 1'b0, "idle_hold");
        step(1'b1, 1'b0, 1'b0, 3'd0, 8'h40, 3'd6, 1'b0, 1'b1, "reenable");

        // Reset in the middle of a scan.
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 1'b1, 1'b0, 3'd0, 8'h01 << (c / 4), 3'(c / 4), 1'b0, 1'b0, "scan_pre_reset");
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_reset", {bus.y, 5'd0, bus.active_idx, 3'd0, bus.wrap, 3'd0, bus.sel_ready}, 32'h0);
        step(1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0, "held_in_reset");
        step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0, "release_idle");
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 3'd0, 8'h01, 3'd0, 1'b0, 1'b1, "direct_after_reset");
        step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0, "final_idle");

        // Parameter sweep: SEL_W=2/DWELL=1 and SEL_W=4/DWELL=3 scanning together.
        @(negedge clk);
        b2.en = 1'b1; b2.mode = 1'b1;
        b4.en = 1'b1; b4.mode = 1'b1;
        wraps2 = 0; wraps4 = 0; first2 = -1; first4 = -1;
        for (int c = 0; c < 96; c++) begin
            @(posedge clk);
            #1;
            e2y = 4'b0001 << (c % 4);
            e4y = 16'h0001 << ((c / 3) % 16);
            chk($sformatf("sweep_w2_c%0d", c), {25'd0, b2.wrap, b2.active_idx, b2.y},
                {25'd0, (c > 0 && c % 4 == 0), 2'(c % 4), e2y});
            chk($sformatf("sweep_w4_c%0d", c), {11'd0, b4.wrap, b4.active_idx, b4.y},
                {11'd0, (c == 48), 4'((c / 3) % 16), e4y});
            if (b2.wrap === 1'b1) begin
                wraps2++;
                if (first2 < 0) first2 = c;
            end
            if (b4.wrap === 1'b1) begin
                wraps4++;
                if (first4 < 0) first4 = c;
            end
        end
        chk("w2_first_wrap", 32'(first2), 32'd4);
        chk("w2_wrap_count", 32'(wraps2), 32'd23);
        chk("w4_first_wrap", 32'(first4), 32'd48);
        chk("w4_wrap_count", 32'(wraps4), 32'd1);

        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/onehot_scan_decoder.md
# onehot_scan_decoder

Registered, parametrised binary-to-one-hot decoder: the successor to our fixed 3-to-8 gate-level decoder. In direct mode it decodes an index accepted over a valid/ready handshake. In scan mode it steps its one-hot output through every position on its own, holding each for a programmable dwell time. It drives row/digit/chip-select lines in display-scan and bus-select paths, where glitch-free registered selects are required.

## Interface
Parameters:
- SEL_W, default 3: index width; the block has N = 2**SEL_W one-hot outputs.
- DWELL, default 4: clock cycles each output is held in scan mode. Legal range is 1 or more; 1 means step every cycle.

Ports:
- clk, input, 1: the only clock; all state updates on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- en, input, 1: block enable; 0 forces the IDLE state.
- mode, input, 1: 0 selects direct decode, 1 selects auto-scan.
- sel_valid, input, 1: a valid index is present on sel.
- sel, input, SEL_W: index to decode in direct mode.
- sel_ready, output, 1: the block accepts sel this cycle.
- y, output, N: registered one-hot select, or all zeros.
- active_idx, output, SEL_W: registered index currently driving y.
- wrap, output, 1: one-cycle pulse in scan mode when active_idx wraps to 0.

## Operation
- State machine with three states: IDLE, DIRECT and SCAN.
- Reset values: state = IDLE, y = 0, active_idx = 0, dwell counter = 0, wrap = 0, sel_ready = 0.
- Transitions are evaluated every clock edge, in this priority order:
  - en = 0: go to IDLE from any state.
  - en = 1 and mode = 0: go to DIRECT.
  - en = 1 and mode = 1: go to SCAN.
- IDLE:
  - y = 0, wrap = 0, sel_ready = 0.
  - active_idx keeps its last value and the dwell counter is cleared.
  - A sel_valid pulse while in IDLE is ignored.
- DIRECT:
  - sel_ready = 1, derived combinationally from the state.
  - On sel_valid & sel_ready, sel is loaded into active_idx and y = 1 << sel, both at that same edge.
  - Entering DIRECT from IDLE or SCAN: y = 1 << active_idx (the retained index) until a new sel is accepted.
  - Consecutive accepts every cycle are legal; there are no bubbles.
- SCAN:
  - sel_ready = 0.
  - Entering SCAN from any state sets active_idx = 0, y = 1, dwell counter = 0.
  - The dwell counter runs 0..DWELL-1. On the edge where it equals DWELL-1, the counter clears and active_idx increments.
  - Wrap-around: active_idx = N-1 increments to 0. wrap is 1 for exactly the cycle in which active_idx first shows 0 after the wrap; it is not asserted on entry to SCAN.
- Invariant, checked every cycle: y is either all zeros (IDLE only) or exactly one-hot, and y == 1 << active_idx whenever state != IDLE.
- Reset mid-operation: all outputs go to their reset values immediately (asynchronous). Operation resumes in IDLE on the first edge after rst_n rises.
- Counter width is max(1, clog2(DWELL)). Index arithmetic is modulo N with no saturation.

## Timing
- Direct-mode latency: sel accepted at edge k gives y valid after edge k. That is one cycle from sel_valid being asserted to y.
- en rising with mode = 0: y is non-zero after the first edge.
- en falling: y = 0 after the next edge.
- Scan period: each index holds for exactly DWELL cycles; a full sweep takes N*DWELL cycles.
- mode toggling while en = 1 takes effect on the next edge. Switching to SCAN always restarts the sweep at index 0.
- All outputs except sel_ready are registered and glitch-free.

## Structure
- Shared package decoder_pkg holds:
  - the state enum (IDLE, DIRECT, SCAN);
  - a function onehot(idx) returning 1 << idx at N bits, reused by later decoder and mux blocks.
- One sub-module, scan_tick_gen:
  - parametrised by DWELL;
  - inputs: clk, rst_n, clear, run;
  - output: tick, asserted when the count equals DWELL-1.
- The top level holds the FSM, the active_idx/y registers and the wrap logic.

## Test plan
- Reset and idle: assert rst_n = 0 mid-scan. Required: y = 0, active_idx = 0, wrap = 0 immediately; state is IDLE after release.
- Direct decode, defaults: en = 1, mode = 0, apply sel = 0..7 on back-to-back cycles with sel_valid = 1. Required: y = 0x01, 0x02, …, 0x80, each one cycle after its sel, sel_ready = 1 throughout.
- Scan sweep, DWELL = 4: en = 1, mode = 1 for 40 cycles. Required:
  - y holds 0x01 for 4 cycles, then 0x02, and so on through 0x80;
  - wrap pulses exactly once, on the return to 0x01 at cycle 32;
  - sel_valid is ignored.
- Mode switch mid-scan: move from SCAN at idx 5 to DIRECT without a new sel. Required: y stays at 0x20 and sel_ready rises. Switching back to SCAN: y = 0x01 and the dwell count restarts.
- Disable: drop en during DIRECT at idx 6. Required: y = 0 next cycle. Re-enable with mode = 0: y = 0x40.
- Parameter sweep (SEL_W = 2, DWELL = 1; SEL_W = 4, DWELL = 3). Required: the one-hot invariant holds, the sweep takes N*DWELL cycles, and wrap fires once per sweep.
